// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 joystick emulator; define JSTK_RESPONDER_SNAPSHOT_EN to freeze X/Y/BTN at frame start.
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] X,
  input  logic [9:0] Y,
  input  logic [2:0] BTN,
  output logic [1:0] LED,
  output logic       FRAME_DONE
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d, sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES:0] flush_q, flush_d;
  logic ss_prev_q, ss_prev_d, sclk_prev_q, sclk_prev_d, armed_q, armed_d;
  logic [2:0] bit_q, bit_d, byte_q, byte_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d;
  logic miso_q, miso_d, done_q, done_d;
  logic [1:0] led_q, led_d;
  logic ss_s, sclk_s, mosi_s, ss_fall_ok, ss_rise, sclk_rise, sclk_fall;
  logic [9:0] src_x, src_y;
  logic [2:0] src_b;
  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                                         input logic [2:0] b);
    return idx == 3'd0 ? x[7:0] : idx == 3'd1 ? {6'b0, x[9:8]} : idx == 3'd2 ? y[7:0] :
           idx == 3'd3 ? {6'b0, y[9:8]} : {5'b0, b};
  endfunction
  assign ss_s       = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  // A falling SS only starts a frame once SS has been seen high after reset.
  assign ss_fall_ok = ss_prev_q & ~ss_s & armed_q;
  assign ss_rise    = ~ss_prev_q & ss_s;
  assign sclk_rise  = ~sclk_prev_q & sclk_s;
  assign sclk_fall  = sclk_prev_q & ~sclk_s;
`ifdef JSTK_RESPONDER_SNAPSHOT_EN
  logic [22:0] snap_q, snap_d;
  assign snap_d = (ss_fall_ok && state_q == IDLE) ? {X, Y, BTN} : snap_q;
  assign {src_x, src_y, src_b} = snap_q;
  always_ff @(posedge CLK) snap_q <= !RST ? 23'd0 : snap_d;
`else
  assign src_x = X;
  assign src_y = Y;
  assign src_b = BTN;
`endif
  always_comb begin
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    ss_prev_d   = ss_s;
    sclk_prev_d = sclk_s;
    flush_d     = {flush_q[SYNC_STAGES-1:0], 1'b1};
    armed_d     = armed_q | (flush_q[SYNC_STAGES] & ss_s);
    state_d     = state_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_d      = miso_q;
    led_d       = led_q;
    done_d      = 1'b0;
    if (ss_rise) begin
      state_d = IDLE;
      bit_d   = 3'd0;
      byte_d  = 3'd0;
      miso_d  = 1'b0;
    end else if (ss_fall_ok && state_q == IDLE) begin
      state_d = SHIFT;
      bit_d   = 3'd0;
      byte_d  = 3'd0;
      tx_d    = tx_byte(3'd0, X, Y, BTN);
      miso_d  = X[7];
    end else if (state_q == SHIFT && sclk_rise) begin
      rx_d  = {rx_q[6:0], mosi_s};
      bit_d = bit_q + 3'd1;
      if (bit_q == 3'd7) begin
        if (byte_q == 3'd0 && rx_d[7:2] == 6'b100000) led_d = rx_d[1:0];
        if (byte_q == 3'd4) begin
          state_d = DONE;
          done_d  = 1'b1;
          miso_d  = 1'b0;
        end else begin
          byte_d = byte_q + 3'd1;
          tx_d   = tx_byte(byte_d, src_x, src_y, src_b);
        end
      end
    end else if (state_q == SHIFT && sclk_fall) begin
      miso_d = tx_q[~bit_q];
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_q       <= 3'd0;
      byte_q      <= 3'd0;
      tx_q        <= 8'd0;
      rx_q        <= 8'd0;
      miso_q      <= 1'b0;
      led_q       <= 2'b00;
      done_q      <= 1'b0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_prev_q   <= ss_prev_d;
      sclk_prev_q <= sclk_prev_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_q      <= miso_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end
  assign MISO       = miso_q;
  assign LED        = led_q;
  assign FRAME_DONE = done_q;
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: SPI master driving joystick frames, scoreboard of expected MISO bytes.
module tb_jstk_spi_responder;
  logic clk = 1'b0, rst = 1'b0, ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic [9:0] x = 10'h2A5, y = 10'h0F3;
  logic [2:0] btn = 3'b101;
  logic miso, frame_done;
  logic [1:0] led;
  logic [7:0] exp_q[$];
  logic [7:0] byte1_exp;
  int checks = 0, errors = 0, fd_cnt = 0, fd_long = 0, fd_base;
  logic fd_prev = 1'b0;
  jstk_spi_responder #(.SYNC_STAGES(2)) dut (
    .CLK(clk), .RST(rst), .SS(ss), .SCLK(sclk), .MOSI(mosi), .MISO(miso),
    .X(x), .Y(y), .BTN(btn), .LED(led), .FRAME_DONE(frame_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (frame_done && fd_prev) fd_long++;
    fd_prev = frame_done;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_frame(input logic [7:0] b1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(8'hF3);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h05);
  endtask
  task automatic frame(input logic [7:0] cmd, input int nbits, input logic chg, input logic [9:0] newx,
                       input logic keep_low);
    logic [7:0] rxb = 8'd0;
    ss = 1'b0;
    mosi = cmd[7];
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      rxb = {rxb[6:0], miso};
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
      mosi = (i < 7) ? cmd[6-i] : 1'b0;
      if (chg && i == 3) x = newx;
      wait_clk(8);
      if (i % 8 == 7) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("miso_byte", 32'(rxb), 32'(exp_q.pop_front()));
      end
    end
    if (!keep_low) begin
      ss = 1'b1;
      wait_clk(16);
    end
  endtask
  initial begin
`ifdef JSTK_RESPONDER_SNAPSHOT_EN
    byte1_exp = 8'h02;
`else
    byte1_exp = 8'h01;
`endif
    wait_clk(5);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b1;
    wait_clk(10);
    fd_base = fd_cnt;
    push_frame(8'h02);
    frame(8'h81, 40, 1'b0, 10'h0, 1'b0);
    chk("led_81", 32'(led), 32'd1);
    chk("fd_full", 32'(fd_cnt - fd_base), 32'd1);
    chk("idle_miso", 32'(miso), 32'd0);
    fd_base = fd_cnt;
    push_frame(8'h02);
    frame(8'h43, 40, 1'b0, 10'h0, 1'b0);
    chk("led_43", 32'(led), 32'd1);
    chk("fd_43", 32'(fd_cnt - fd_base), 32'd1);
    fd_base = fd_cnt;
    exp_q.push_back(8'hA5);
    frame(8'h82, 12, 1'b0, 10'h0, 1'b0);
    chk("led_abort", 32'(led), 32'd2);
    chk("fd_abort", 32'(fd_cnt - fd_base), 32'd0);
    fd_base = fd_cnt;
    push_frame(8'h02);
    frame(8'h00, 40, 1'b0, 10'h0, 1'b0);
    chk("led_00", 32'(led), 32'd2);
    chk("fd_restart", 32'(fd_cnt - fd_base), 32'd1);
    fd_base = fd_cnt;
    push_frame(8'h02);
    exp_q.push_back(8'h00);
    frame(8'h00, 48, 1'b0, 10'h0, 1'b0);
    chk("fd_48", 32'(fd_cnt - fd_base), 32'd1);
    push_frame(byte1_exp);
    frame(8'h00, 40, 1'b1, 10'h1FF, 1'b0);
    x = 10'h2A5;
    fd_base = fd_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h02);
    frame(8'h83, 20, 1'b0, 10'h0, 1'b1);
    chk("led_83", 32'(led), 32'd3);
    rst = 1'b0;
    wait_clk(3);
    chk("rst_mid_miso", 32'(miso), 32'd0);
    chk("rst_mid_led", 32'(led), 32'd0);
    rst = 1'b1;
    wait_clk(20);
    exp_q.push_back(8'h00);
    frame(8'h81, 8, 1'b0, 10'h0, 1'b1);
    chk("led_noresp", 32'(led), 32'd0);
    chk("fd_noresp", 32'(fd_cnt - fd_base), 32'd0);
    ss = 1'b1;
    wait_clk(16);
    push_frame(8'h02);
    frame(8'h81, 40, 1'b0, 10'h0, 1'b0);
    chk("led_after_rst", 32'(led), 32'd1);
    chk("fd_after_rst", 32'(fd_cnt - fd_base), 32'd1);
    chk("fd_width", 32'(fd_long), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jstk_spi_responder.md
JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in each SS/SCLK/MOSI synchronizer chain (minimum 2).
REQ-002 SHALL have port CLK  input  1  system clock (at least 8x SCLK frequency).
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-low; one clock, CLK.
REQ-004 SHALL have port SS  input  1  slave select from master, active-low, asynchronous to CLK.
REQ-005 SHALL have port SCLK  input  1  SPI serial clock from master (66.67 kHz nominal), asynchronous to CLK.
REQ-006 SHALL have port MOSI  input  1  master-out data.
REQ-007 SHALL have port MISO  output  1  slave-out data.
REQ-008 SHALL have port X  input  10  emulated joystick X position.
REQ-009 SHALL have port Y  input  10  emulated joystick Y position.
REQ-010 SHALL have port BTN  input  3  emulated buttons {trigger, btn1, btn0}.
REQ-011 SHALL have port LED  output  2  LED state last commanded by master.
REQ-012 SHALL have port FRAME_DONE  output  1  one-CLK pulse on completion of a full 40-bit frame.

Function
REQ-013 SHALL synchronize SS, SCLK and MOSI through SYNC_STAGES flops, then detect edges on the synchronized SS and SCLK with one further register stage.
REQ-014 SPI mode 0: SHALL sample MOSI on synchronized SCLK rising edge, update MISO on synchronized SCLK falling edge, MSB first.
REQ-015 State machine IDLE, SHIFT, DONE; IDLE -> SHIFT on SS falling edge; SHIFT -> DONE after 40th rising edge; any state -> IDLE on SS rising edge.
REQ-016 On SS falling edge SHALL load tx byte 0 and drive its MSB on MISO in the same CLK cycle the edge is detected.
REQ-017 Tx bytes in order: B0 = X[7:0], B1 = {6'b0, X[9:8]}, B2 = Y[7:0], B3 = {6'b0, Y[9:8]}, B4 = {5'b0, BTN}.
REQ-018 Bit counter 3-bit, byte index 0..4; on 8th rising edge of a byte, next tx byte SHALL be loaded so its MSB appears on the following falling edge.
REQ-019 First received byte is the command; if cmd[7:2] == 6'b100000, LED SHALL update to cmd[1:0] on the CLK after the 8th rising edge; otherwise LED unchanged.
REQ-020 Received bytes 1..4 SHALL be ignored.
REQ-021 FRAME_DONE SHALL pulse high for exactly one CLK, one CLK after the 40th rising edge is detected.
REQ-022 In DONE (more than 40 SCLKs with SS low), MISO SHALL drive 0 and further edges SHALL be ignored; no second FRAME_DONE.
REQ-023 SS rising mid-frame: abort to IDLE, no FRAME_DONE; LED update only if byte 0 already completed.
REQ-024 SS high (IDLE): MISO SHALL drive 0; SCLK edges ignored.
REQ-025 SS falling and SCLK edge detected in the same CLK: SS edge takes priority, SCLK edge discarded.

Reset
REQ-026 RST low at a CLK rising edge SHALL force state IDLE, counters 0, MISO 0, LED 2'b00, FRAME_DONE 0, synchronizers to SS=1, SCLK=0, MOSI=0.
REQ-027 RST asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh SS falling edge even if SS is already low.

Configuration
REQ-028 Macro JSTK_RESPONDER_SNAPSHOT_EN: defined -> X, Y, BTN captured into a 23-bit snapshot register on SS falling edge, all five bytes built from the snapshot (coherent frame).
REQ-029 Without JSTK_RESPONDER_SNAPSHOT_EN: no snapshot register; each tx byte built from live X/Y/BTN at the moment it is loaded.

Verification
REQ-030 X=10'h2A5, Y=10'h0F3, BTN=3'b101, full 40-bit frame, MOSI cmd 8'h81 -> MISO bytes A5,02,F3,00,05; LED=2'b01; one FRAME_DONE pulse.
REQ-031 Cmd 8'h43 -> LED unchanged from previous value 2'b01; bytes still returned correctly.
REQ-032 SS raised after 12 SCLKs with cmd 8'h82 -> LED=2'b10, no FRAME_DONE; next frame starts again at byte 0.
REQ-033 48 SCLKs with SS low -> bytes 0..4 correct, 6th byte reads 00, exactly one FRAME_DONE.
REQ-034 SNAPSHOT_EN defined, X changed 10'h2A5 -> 10'h1FF during byte 0 -> MISO byte 1 = 02; macro undefined, same stimulus -> byte 1 = 01.
REQ-035 RST low during byte 2 with SS held low, then released -> MISO 0, LED 00, no response until SS toggles high then low.
